// File: rtl/mac_tx_arbiter.sv
// mac_tx_arbiter: frame-granular round-robin share of the MAC TX stream
// between ARP, ICMP and UDP builders, with inter-frame gap and stall abort.
module mac_tx_arbiter #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        tx_mac_aclk,
    input  logic        tx_mac_resetn,
    input  logic [23:0] s_axis_tdata,
    input  logic [2:0]  s_axis_tvalid,
    input  logic [2:0]  s_axis_tlast,
    output logic [2:0]  s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    output logic [1:0]  grant,
    output logic        frame_abort
);

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        ABORT,
        DRAIN,
        GAP
    } state_t;

    localparam logic [15:0] TO_LAST =
        (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST =
        (IFG_CYCLES == 0) ? 16'd0 : 16'(IFG_CYCLES - 1);
    localparam bit HAS_TO = (TIMEOUT != 0);
    localparam state_t AFTER_FRAME = (IFG_CYCLES == 0) ? IDLE : GAP;

    state_t      state;
    logic [1:0]  rr;
    logic [15:0] to_cnt;
    logic [15:0] gap_cnt;
    logic [1:0]  pick;
    logic [2:0]  sel;
    logic [7:0]  src_data;
    logic        src_valid;
    logic        src_last;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    // first requester searching rr, rr+1, rr+2 (mod 3)
    always_comb begin
        pick = rr;
        if (!s_axis_tvalid[rr]) begin
            pick = inc3(rr);
            if (!s_axis_tvalid[inc3(rr)]) begin
                pick = inc3(inc3(rr));
            end
        end
    end

    always_comb begin
        sel      = 3'b000;
        src_data = 8'h00;
        case (grant)
            2'd0: begin
                sel      = 3'b001;
                src_data = s_axis_tdata[7:0];
            end
            2'd1: begin
                sel      = 3'b010;
                src_data = s_axis_tdata[15:8];
            end
            2'd2: begin
                sel      = 3'b100;
                src_data = s_axis_tdata[23:16];
            end
            default: ;
        endcase
    end

    assign src_valid = |(s_axis_tvalid & sel);
    assign src_last  = |(s_axis_tlast & sel);

    always_comb begin
        s_axis_tready = 3'b000;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        frame_abort   = 1'b0;
        unique case (state)
            PASS: begin
                s_axis_tready = sel & {3{m_axis_tready}};
                m_axis_tdata  = src_data;
                m_axis_tvalid = src_valid;
                m_axis_tlast  = src_last;
            end
            ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = 1'b1;
                m_axis_tuser  = 1'b1;
                frame_abort   = m_axis_tready;
            end
            DRAIN: s_axis_tready = sel;
            default: ;
        endcase
    end

    always_ff @(posedge tx_mac_aclk) begin
        if (!tx_mac_resetn) begin
            state   <= IDLE;
            rr      <= 2'd0;
            grant   <= 2'd3;
            to_cnt  <= 16'd0;
            gap_cnt <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant  <= pick;
                        to_cnt <= 16'd0;
                        state  <= PASS;
                    end
                end
                PASS: begin
                    if (src_valid) begin
                        to_cnt <= 16'd0;
                        if (m_axis_tready && src_last) begin
                            rr      <= inc3(grant);
                            grant   <= 2'd3;
                            gap_cnt <= 16'd0;
                            state   <= AFTER_FRAME;
                        end
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                        // the increment that reaches TIMEOUT moves to ABORT
                        if (HAS_TO && to_cnt == TO_LAST) begin
                            state <= ABORT;
                        end
                    end
                end
                ABORT: begin
                    if (m_axis_tready) begin
                        rr    <= inc3(grant);
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (src_valid && src_last) begin
                        grant   <= 2'd3;
                        gap_cnt <= 16'd0;
                        state   <= AFTER_FRAME;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb_mac_tx_arbiter: random-data frame traffic against a frame-level
// round-robin reference model with gap, abort and reset checks.
module tb_mac_tx_arbiter;

    localparam int IFG = 12;
    localparam int TMO = 16;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       l;
        logic       u;
        logic [1:0] g;
    } beat_t;

    logic        tx_mac_aclk = 1'b0;
    logic        tx_mac_resetn;
    logic [23:0] s_axis_tdata;
    logic [2:0]  s_axis_tvalid;
    logic [2:0]  s_axis_tlast;
    logic [2:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready;
    logic [1:0]  grant;
    logic        frame_abort;

    logic [2:0]  vld;
    logic [2:0]  lst;
    logic [7:0]  dat [3];

    logic [8:0]  q  [3][$];
    logic [8:0]  fq [3][$];
    beat_t       ob [$];
    beat_t       exp_q [$];
    int          ab_q [$];

    int hold [3];
    int stall_cnt [3];
    int rise [3];
    int sacc [3];
    int sacc_cyc [3];
    int stall_len;
    int cyc;
    int m_rr;
    int n_chk;
    int n_bad;
    bit rdy_rand;

    assign s_axis_tdata  = {dat[2], dat[1], dat[0]};
    assign s_axis_tvalid = vld;
    assign s_axis_tlast  = lst;

    always #5 tx_mac_aclk = ~tx_mac_aclk;

    mac_tx_arbiter #(
        .IFG_CYCLES(IFG),
        .TIMEOUT   (TMO)
    ) dut (
        .tx_mac_aclk  (tx_mac_aclk),
        .tx_mac_resetn(tx_mac_resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .grant        (grant),
        .frame_abort  (frame_abort)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // one clock: observe mid-cycle, then drive sources after the edge
    task automatic step();
        bit         acc [3];
        bit         rs;
        bit         nv;
        logic [2:0] oh;
        logic [8:0] h;
        @(negedge tx_mac_aclk);
        if (m_axis_tvalid && m_axis_tready) begin
            ob.push_back('{cyc, m_axis_tdata, m_axis_tlast,
                           m_axis_tuser, grant});
        end
        if (frame_abort) ab_q.push_back(cyc);
        for (int i = 0; i < 3; i++) begin
            acc[i] = vld[i] && s_axis_tready[i];
            if (acc[i]) begin
                sacc[i]++;
                sacc_cyc[i] = cyc;
            end
        end
        case (grant)
            2'd0: oh = 3'b001;
            2'd1: oh = 3'b010;
            2'd2: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        chk("rdy_excl", 32'(s_axis_tready & ~oh), 0);
        if (m_axis_tvalid && !m_axis_tuser) begin
            chk("rdy_mirror", 32'(s_axis_tready),
                32'(oh & {3{m_axis_tready}}));
        end
        rs = tx_mac_resetn;
        @(posedge tx_mac_aclk);
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (!rs) begin
                q[i].delete();
                hold[i] = 0;
                stall_cnt[i] = 0;
            end else if (acc[i]) begin
                if (q[i].size() > 0) void'(q[i].pop_front());
                if (stall_cnt[i] > 0) begin
                    stall_cnt[i]--;
                    if (stall_cnt[i] == 0) hold[i] = stall_len;
                end
            end
            if (hold[i] > 0) begin
                hold[i]--;
                nv = 1'b0;
            end else begin
                nv = (q[i].size() > 0);
            end
            if (nv && !vld[i]) rise[i] = cyc;
            h = nv ? q[i][0] : 9'h000;
            vld[i] = nv;
            dat[i] = h[7:0];
            lst[i] = h[8];
        end
        m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic push_frame(input int src, input int len, input bit cnt);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = cnt ? 8'(k) : 8'($urandom);
            q[src].push_back({k == len - 1, b});
            fq[src].push_back({k == len - 1, b});
        end
    endtask

    // round-robin choice among the sources with a frame pending
    function automatic int model_next(input logic [2:0] pend);
        int s;
        for (int k = 0; k < 3; k++) begin
            s = (m_rr + k) % 3;
            if (pend[s]) begin
                m_rr = (s + 1) % 3;
                return s;
            end
        end
        return 3;
    endfunction

    task automatic expect_frame(input int src);
        logic [8:0] e;
        while (fq[src].size() > 0) begin
            e = fq[src].pop_front();
            exp_q.push_back('{0, e[7:0], e[8], 1'b0, 2'(src)});
            if (e[8]) break;
        end
    endtask

    task automatic expect_abort(input int src, input int nsent);
        logic [8:0] e;
        for (int k = 0; k < nsent; k++) begin
            e = fq[src].pop_front();
            exp_q.push_back('{0, e[7:0], 1'b0, 1'b0, 2'(src)});
        end
        exp_q.push_back('{0, 8'h00, 1'b1, 1'b1, 2'(src)});
        while (fq[src].size() > 0) begin
            e = fq[src].pop_front();
            if (e[8]) break;
        end
    endtask

    task automatic compare(input string t);
        chk({t, "_nbeats"}, ob.size(), exp_q.size());
        for (int i = 0; i < ob.size() && i < exp_q.size(); i++) begin
            chk({t, "_data"}, 32'(ob[i].d), 32'(exp_q[i].d));
            chk({t, "_last"}, 32'(ob[i].l), 32'(exp_q[i].l));
            chk({t, "_user"}, 32'(ob[i].u), 32'(exp_q[i].u));
            chk({t, "_grant"}, 32'(ob[i].g), 32'(exp_q[i].g));
        end
    endtask

    task automatic check_gaps(input string t);
        for (int i = 0; i + 1 < ob.size(); i++) begin
            if (ob[i].l) chk(t, ob[i + 1].cyc - ob[i].cyc, IFG + 2);
        end
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            step();
            ok = q[0].size() == 0 && q[1].size() == 0 &&
                 q[2].size() == 0 && grant == 2'd3;
        end
        chk("wait_done", 32'(ok), 1);
        repeat (IFG + 4) step();
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int c = 0; c < budget && ob.size() < n; c++) step();
        chk("wait_beats", 32'(ob.size() >= n), 1);
    endtask

    task automatic clear_obs();
        ob.delete();
        exp_q.delete();
        ab_q.delete();
    endtask

    task automatic check_idle_outputs(input string t);
        chk({t, "_tvalid"}, 32'(m_axis_tvalid), 0);
        chk({t, "_tlast"}, 32'(m_axis_tlast), 0);
        chk({t, "_tuser"}, 32'(m_axis_tuser), 0);
        chk({t, "_tdata"}, 32'(m_axis_tdata), 0);
        chk({t, "_sready"}, 32'(s_axis_tready), 0);
        chk({t, "_grant"}, 32'(grant), 3);
        chk({t, "_abort"}, 32'(frame_abort), 0);
    endtask

    initial begin
        int s;
        int a0;
        n_chk = 0;
        n_bad = 0;
        cyc = 0;
        m_rr = 0;
        rdy_rand = 1'b0;
        stall_len = 0;
        vld = 3'b000;
        lst = 3'b000;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dat[i] = 8'h00;
            hold[i] = 0;
            stall_cnt[i] = 0;
            rise[i] = 0;
            sacc[i] = 0;
            sacc_cyc[i] = 0;
        end
        tx_mac_resetn = 1'b0;
        repeat (3) step();
        tx_mac_resetn = 1'b1;
        check_idle_outputs("reset");

        // single UDP frame, counting bytes
        clear_obs();
        push_frame(2, 60, 1'b1);
        s = model_next(3'b100);
        expect_frame(s);
        wait_done(400);
        compare("udp1");
        if (ob.size() == 60) begin
            chk("udp1_latency", ob[0].cyc, rise[2] + 1);
            chk("udp1_span", ob[59].cyc - ob[0].cyc, 59);
        end

        // all three request together after reset
        tx_mac_resetn = 1'b0;
        step();
        tx_mac_resetn = 1'b1;
        m_rr = 0;
        clear_obs();
        for (int i = 0; i < 3; i++) push_frame(i, $urandom_range(4, 20), 1'b0);
        begin
            logic [2:0] pend;
            pend = 3'b111;
            for (int k = 0; k < 3; k++) begin
                s = model_next(pend);
                pend[s] = 1'b0;
                expect_frame(s);
            end
        end
        wait_done(600);
        compare("rr3");
        check_gaps("rr3_gap");
        if (ob.size() > 0) chk("rr3_latency", ob[0].cyc, rise[0] + 1);

        // UDP keeps requesting, ARP arrives mid-frame
        clear_obs();
        push_frame(2, 20, 1'b0);
        push_frame(2, 12, 1'b0);
        s = model_next(3'b100);
        expect_frame(s);
        wait_beats(5, 100);
        push_frame(0, 10, 1'b0);
        s = model_next(3'b101);
        expect_frame(s);
        s = model_next(3'b100);
        expect_frame(s);
        wait_done(600);
        compare("pre");
        check_gaps("pre_gap");
        if (ob.size() >= 20) chk("pre_contig", ob[19].cyc - ob[0].cyc, 19);

        // ICMP under random back-pressure
        clear_obs();
        rdy_rand = 1'b1;
        push_frame(1, 100, 1'b0);
        s = model_next(3'b010);
        expect_frame(s);
        wait_done(2000);
        rdy_rand = 1'b0;
        compare("bp");

        // ARP stalls after 10 of 42 bytes, ICMP waits behind it
        clear_obs();
        a0 = sacc[0];
        stall_len = 20;
        stall_cnt[0] = 10;
        push_frame(0, 42, 1'b0);
        s = model_next(3'b001);
        expect_abort(s, 10);
        wait_beats(10, 100);
        push_frame(1, 8, 1'b0);
        s = model_next(3'b010);
        expect_frame(s);
        wait_done(600);
        compare("abort");
        chk("abort_pulses", ab_q.size(), 1);
        chk("abort_drained", sacc[0] - a0, 42);
        if (ob.size() >= 12) begin
            chk("abort_delay", ob[10].cyc - ob[9].cyc, TMO + 1);
            chk("abort_next_gap", ob[11].cyc - sacc_cyc[0], IFG + 2);
            if (ab_q.size() > 0) chk("abort_pulse_cyc", ab_q[0], ob[10].cyc);
        end

        // reset during byte 30 of a UDP frame
        clear_obs();
        push_frame(2, 60, 1'b1);
        wait_beats(29, 100);
        tx_mac_resetn = 1'b0;
        step();
        tx_mac_resetn = 1'b1;
        check_idle_outputs("midrst");
        for (int i = 0; i < 3; i++) fq[i].delete();
        m_rr = 0;
        clear_obs();
        push_frame(1, 8, 1'b0);
        push_frame(2, 8, 1'b0);
        s = model_next(3'b110);
        expect_frame(s);
        s = model_next(3'b100);
        expect_frame(s);
        wait_done(400);
        compare("postrst");
        check_gaps("postrst_gap");
        if (ob.size() > 0) chk("postrst_latency", ob[0].cyc, rise[1] + 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_tx_arbiter.md
# mac_tx_arbiter

Frame-granular arbiter that shares the single MAC transmit AXI-Stream between three frame sources: ARP, ICMP (IP) and UDP (IP). It holds a grant from the first beat of a frame through its tlast handshake. It also enforces a minimum idle gap between frames and aborts frames whose source stalls, so the MAC is never held indefinitely. It sits between the protocol TX builders and the MAC TX interface, mirroring the RX-side split by ethertype/protocol.

## Interface
Parameters:
- IFG_CYCLES, 12: idle cycles inserted after each frame (GAP state); 0 = no gap.
- TIMEOUT, 1024: consecutive idle-source cycles mid-frame before abort; 0 = abort disabled. 16-bit counter.

Ports:
- tx_mac_aclk  in  1  sole clock.
- tx_mac_resetn  in  1  reset; synchronous, active-low.
- s_axis_tdata  in  24  source data, [8i+7:8i] for source i (0 ARP, 1 ICMP, 2 UDP).
- s_axis_tvalid  in  3  per-source valid.
- s_axis_tlast  in  3  per-source last.
- s_axis_tready  out  3  per-source ready.
- m_axis_tdata  out  8  to MAC.
- m_axis_tvalid  out  1  to MAC.
- m_axis_tlast  out  1  to MAC.
- m_axis_tuser  out  1  1 = frame aborted (set only on the abort beat).
- m_axis_tready  in  1  from MAC.
- grant  out  2  current source, 2'd3 = none.
- frame_abort  out  1  one-cycle pulse when an abort beat is accepted.

## Operation
- States: IDLE, PASS, ABORT, DRAIN, GAP. Reset state is IDLE.
- Round-robin pointer rr (2 bits, values 0–2). Reset value 0. Search order: rr, rr+1, rr+2 mod 3.
- IDLE: grant=3, all s_tready=0, m_tvalid=0.
  - If any s_tvalid, latch the first requesting source in search order into grant and go to PASS.
  - Otherwise stay in IDLE.
- PASS:
  - m_tdata/m_tvalid/m_tlast come combinationally from source grant; m_tuser=0.
  - s_tready[grant]=m_tready; other s_tready=0.
  - On a handshake with tlast: rr←grant+1 mod 3, then go to GAP (or IDLE if IFG_CYCLES=0).
- Timeout counter:
  - Clears on entry to PASS and on every cycle where s_tvalid[grant]=1.
  - Increments on every PASS cycle where s_tvalid[grant]=0.
  - When it reaches TIMEOUT, go to ABORT next cycle. Disabled when TIMEOUT=0.
- ABORT:
  - Drive m_tvalid=1, m_tlast=1, m_tuser=1, m_tdata=8'h00; all s_tready=0.
  - Hold until m_tready. On that handshake pulse frame_abort, set rr←grant+1, go to DRAIN.
- DRAIN:
  - s_tready[grant]=1, m_tvalid=0; discard beats of source grant.
  - On an accepted beat with tlast, go to GAP (or IDLE). grant stays set to the aborted source until then.
- GAP:
  - grant=3, all s_tready=0, m_tvalid=0.
  - Count IFG_CYCLES cycles, then go to IDLE.
- Sources requesting during PASS/ABORT/DRAIN/GAP wait; they must hold tvalid/data stable (AXI-S rule). The arbiter never drops a waiting frame.
- Simultaneous tlast handshake and timeout expiry cannot occur: valid clears the counter. A tlast handshake always wins.
- Reset asserted mid-frame:
  - Next edge forces IDLE; rr=0; all outputs drop.
  - Downstream sees a frame without tlast; the MAC handles that as an underrun.
  - Sources are expected to be reset by the same reset.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=3'b000, grant=2'd3, frame_abort=0.
- Arbitration latency: a source whose tvalid rises in IDLE at cycle N gets grant at N+1. Its first byte appears on m_axis at N+1 (zero data latency in PASS).
- Inter-frame spacing: last-beat handshake at cycle N; earliest next first beat at N+IFG_CYCLES+2 (IFG_CYCLES GAP cycles plus one IDLE decision cycle).
- Abort: last source-valid beat at cycle N; if the source stays idle, ABORT is entered at N+TIMEOUT+1 and the abort beat is presented from that cycle.
- Back-to-back is throughput-neutral within a frame: one byte per cycle while m_tready=1 and the source is valid.

## Test plan
- Single UDP frame, 60 bytes 0x00..0x3B, m_tready=1 → grant=2 one cycle after tvalid; 60 bytes appear unchanged with tlast on byte 0x3B; s_tready[0,1]=0 throughout.
- All three sources valid in IDLE after reset, IFG_CYCLES=12 → frames emitted in order ARP, ICMP, UDP; 13 idle cycles between each last beat and the next first beat.
- UDP continuously requesting, ARP requests mid-UDP frame → UDP frame completes uninterrupted, then ARP is granted (rr=0 after UDP); UDP is not served twice in a row.
- Random m_tready toggling (50%) over a 100-byte ICMP frame → output byte sequence identical; no duplicated or lost beats; s_tready mirrors m_tready.
- TIMEOUT=16, ARP stalls after 10 of 42 bytes for 20 cycles → abort beat (tdata=0, tlast=1, tuser=1) 17 cycles after the 10th byte; frame_abort pulses once; remaining 32 bytes drained with m_tvalid=0; then GAP.
- tx_mac_resetn low for one cycle during byte 30 of a UDP frame → all outputs 0 and grant=3 on the next cycle; after release, a new ICMP request is granted normally with rr=0 order.
